// File: rtl/jtkiwi_shram_arb.sv
// Shared-RAM arbiter: PORTS request/ack masters, round-robin with per-port
// bus lock, one access every three clocks, registered read data.
module jtkiwi_shram_arb #(
    parameter int PORTS    = 2,
    parameter int AW       = 13,
    parameter int DW       = 8,
    parameter int LOCKMASK = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cen,
    input  logic [PORTS-1:0]    req,
    input  logic [PORTS-1:0]    rnw,
    input  logic [PORTS*AW-1:0] addr,
    input  logic [PORTS*DW-1:0] din,
    input  logic [PORTS-1:0]    lock,
    output logic [PORTS-1:0]    ack,
    output logic [DW-1:0]       dout,
    output logic [2:0]          owner,
    output logic                busy
);

    localparam logic [7:0] LMASK = 8'(LOCKMASK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, state_nx;

    // Per-port vectors widened to 8 so the 3-bit owner can index them directly
    logic [7:0] req8, lock8, rnw8;
    logic       win_vld;
    logic [2:0] win;
    logic       grant;

    // Request latched at grant, consumed by the RAM in ACCESS
    logic          rnw_p1;
    logic [AW-1:0] addr_p1;
    logic [DW-1:0] din_p1;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    assign req8  = 8'(req);
    assign lock8 = 8'(lock);
    assign rnw8  = 8'(rnw);

    // Winner: locked owner excludes everyone else; otherwise nearest request after owner
    always_comb begin : pick_winner
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win     = owner;
        if (lock8[owner] && LMASK[owner]) begin
            win_vld = req8[owner];
        end else begin
            // Scan farthest first so the nearest requester overrides
            for (int k = PORTS; k >= 1; k--) begin
                idx = (int'(owner) + k) % PORTS;
                if (req8[3'(idx)]) begin
                    win_vld = 1'b1;
                    win     = 3'(idx);
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state: grant only from IDLE with cen, then two fixed steps
    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        case (state)
            IDLE: begin
                if (cen && win_vld) begin
                    grant    = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Owner tracking and registered read data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner <= 3'(PORTS-1);
            dout  <= '0;
        end else begin
            if (grant) owner <= win;
            if (state == ACCESS && rnw_p1) dout <= mem[addr_p1];
        end
    end

    // Capture the winner's request at the grant edge
    always_ff @(posedge clk) begin
        if (grant) begin
            rnw_p1  <= rnw8[win];
            addr_p1 <= addr[int'(win)*AW +: AW];
            din_p1  <= din[int'(win)*DW +: DW];
        end
    end

    // RAM write; an async reset forces IDLE so an interrupted write is dropped
    always_ff @(posedge clk) begin
        if (state == ACCESS && !rnw_p1) mem[addr_p1] <= din_p1;
    end

    // Completion pulse to the owner during DONE
    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            ack[i] = (state == DONE) && (3'(i) == owner);
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_jtkiwi_shram_arb.sv
// Bench for jtkiwi_shram_arb: a PORTS=2 and a PORTS=4 instance checked every
// cycle against a transaction-level model, plus directed scenario checks.
module tb_jtkiwi_shram_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn = 1'b0;
    logic cena = 1'b0, cenb = 1'b0;

    logic [1:0]  reqa = '0, rnwa = '0, locka = '0;
    logic [25:0] addra = '0;
    logic [15:0] dina = '0;
    logic [1:0]  acka;
    logic [7:0]  douta;
    logic [2:0]  owna;
    logic        busya;

    logic [3:0]  reqb = '0, rnwb = '0, lockb = '0;
    logic [39:0] addrb = '0;
    logic [31:0] dinb = '0;
    logic [3:0]  ackb;
    logic [7:0]  doutb;
    logic [2:0]  ownb;
    logic        busyb;

    jtkiwi_shram_arb #(.PORTS(2), .AW(13), .DW(8), .LOCKMASK(1)) dut_a (
        .clk(clk), .rstn(rstn), .cen(cena), .req(reqa), .rnw(rnwa),
        .addr(addra), .din(dina), .lock(locka), .ack(acka), .dout(douta),
        .owner(owna), .busy(busya)
    );

    jtkiwi_shram_arb #(.PORTS(4), .AW(10), .DW(8), .LOCKMASK(5)) dut_b (
        .clk(clk), .rstn(rstn), .cen(cenb), .req(reqb), .rnw(rnwb),
        .addr(addrb), .din(dinb), .lock(lockb), .ack(ackb), .dout(doutb),
        .owner(ownb), .busy(busyb)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: m_cnt counts edges left in the current transaction
    // (0 = free, 2 = granted, 1 = completing/acking)
    int         NP [2] = '{2, 4};
    logic [7:0] LM [2] = '{8'h01, 8'h05};
    int         m_cnt [2];
    int         m_own [2];
    logic [7:0] m_dout [2];
    logic       m_rw [2];
    int         m_ad [2];
    logic [7:0] m_dt [2];
    logic [7:0] ma [0:8191];
    logic [7:0] mb [0:1023];

    int         qa[$], qta[$], qb[$];
    logic [7:0] qdb[$];
    int         cyc = 0, ack1_cnt = 0, acka_cnt = 0;
    int         ka [4] = '{32'h0123, 32'h0010, 32'h0200, 32'h1FFF};
    int         kb [4] = '{32'h000, 32'h155, 32'h2AA, 32'h3FF};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int d, input logic [7:0] rq, input logic [7:0] lk);
        int o = m_own[d];
        if (lk[o] && LM[d][o]) return rq[o] ? o : -1;
        for (int k = 1; k <= NP[d]; k++) begin
            int i = (o + k) % NP[d];
            if (rq[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset(input int d);
        m_cnt[d]  = 0;
        m_own[d]  = NP[d] - 1;
        m_dout[d] = 8'h00;
    endtask

    task automatic model_edge(input int d);
        logic [7:0] rq, lk;
        logic       c;
        int         w;
        rq = (d == 0) ? 8'(reqa) : 8'(reqb);
        lk = (d == 0) ? 8'(locka) : 8'(lockb);
        c  = (d == 0) ? cena : cenb;
        case (m_cnt[d])
            0: if (c) begin
                w = pick(d, rq, lk);
                if (w >= 0) begin
                    m_own[d] = w;
                    m_cnt[d] = 2;
                    if (d == 0) begin
                        m_rw[0] = rnwa[w]; m_ad[0] = int'(addra[w*13 +: 13]); m_dt[0] = dina[w*8 +: 8];
                    end else begin
                        m_rw[1] = rnwb[w]; m_ad[1] = int'(addrb[w*10 +: 10]); m_dt[1] = dinb[w*8 +: 8];
                    end
                end
            end
            2: begin
                if (m_rw[d]) m_dout[d] = (d == 0) ? ma[m_ad[d]] : mb[m_ad[d]];
                else if (d == 0) ma[m_ad[d]] = m_dt[d];
                else mb[m_ad[d]] = m_dt[d];
                m_cnt[d] = 1;
            end
            default: m_cnt[d] = 0;
        endcase
    endtask

    task automatic check_all();
        chk("ack_a", 32'(acka), (m_cnt[0] == 1) ? (32'd1 << m_own[0]) : 32'd0);
        chk("busy_a", 32'(busya), 32'(m_cnt[0] != 0));
        chk("owner_a", 32'(owna), 32'(m_own[0]));
        chk("dout_a", 32'(douta), 32'(m_dout[0]));
        chk("ack_b", 32'(ackb), (m_cnt[1] == 1) ? (32'd1 << m_own[1]) : 32'd0);
        chk("busy_b", 32'(busyb), 32'(m_cnt[1] != 0));
        chk("owner_b", 32'(ownb), 32'(m_own[1]));
        chk("dout_b", 32'(doutb), 32'(m_dout[1]));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rstn) begin
            model_reset(0); model_reset(1);
        end else begin
            model_edge(0); model_edge(1);
        end
        #1;
        cyc++;
        check_all();
        if (acka != 0) begin
            qa.push_back(int'(acka)); qta.push_back(cyc); acka_cnt++;
            if (acka[1]) ack1_cnt++;
        end
        if (ackb != 0) begin
            qb.push_back(int'(ackb)); qdb.push_back(doutb);
        end
    endtask

    // Raise one request, wait (bounded) for its ack, then drop it
    task automatic do_acc(input int d, input int p, input logic rw, input int a,
                          input logic [7:0] dt, output int n);
        logic got = 1'b0;
        if (d == 0) begin
            reqa[p] = 1'b1; rnwa[p] = rw; addra[p*13 +: 13] = 13'(a); dina[p*8 +: 8] = dt;
        end else begin
            reqb[p] = 1'b1; rnwb[p] = rw; addrb[p*10 +: 10] = 10'(a); dinb[p*8 +: 8] = dt;
        end
        n = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            n++;
            got = (d == 0) ? acka[p] : ackb[p];
        end
        chk("acc_ack_seen", 32'(got), 32'd1);
        if (d == 0) reqa[p] = 1'b0;
        else        reqb[p] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int n;
        model_reset(0); model_reset(1);
        repeat (2) step();
        chk("rst_busy_a", 32'(busya), 32'd0);
        chk("rst_ack_a", 32'(acka), 32'd0);
        chk("rst_owner_a", 32'(owna), 32'd1);
        chk("rst_dout_a", 32'(douta), 32'd0);
        chk("rst_owner_b", 32'(ownb), 32'd3);
        chk("rst_dout_b", 32'(doutb), 32'd0);
        rstn = 1'b1; cena = 1'b1; cenb = 1'b1;
        step();

        // Single write then read
        do_acc(0, 0, 1'b0, 'h0123, 8'h5A, n);
        chk("wr_latency", 32'(n), 32'd2);
        step();
        do_acc(0, 0, 1'b1, 'h0123, 8'h00, n);
        chk("rd_latency", 32'(n), 32'd2);
        chk("rd_data", 32'(douta), 32'h5A);
        do_acc(0, 0, 1'b0, 'h0010, 8'h33, n);
        do_acc(0, 1, 1'b0, 'h0200, 8'hC4, n);
        do_acc(0, 1, 1'b0, 'h1FFF, 8'h81, n);
        step();

        // Contention right after reset
        rstn = 1'b0; model_reset(0); model_reset(1);
        step();
        rstn = 1'b1;
        rnwa = 2'b11; addra = {13'h0123, 13'h0123}; reqa = 2'b11;
        qa.delete(); qta.delete();
        repeat (12) step();
        reqa = 2'b00;
        chk("cont_count", 32'(qa.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("cont_order", (i < qa.size()) ? 32'(qa[i]) : 32'hFFFF, 32'd1 << (i % 2));
        for (int i = 1; i < 4; i++)
            chk("cont_gap", (i < qta.size()) ? 32'(qta[i] - qta[i-1]) : 32'hFFFF, 32'd3);

        // Lock held by port 0 while port 1 requests continuously
        locka = 2'b01; rnwa[1] = 1'b1; addra[13 +: 13] = 13'h0123; reqa[1] = 1'b1;
        ack1_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            do_acc(0, 0, i[0], 'h0200, 8'h10 + 8'(i), n);
        end
        chk("lock_ack1", 32'(ack1_cnt), 32'd0);
        locka = 2'b00;
        do_acc(0, 1, 1'b1, 'h0123, 8'h00, n);
        chk("unlock_grant", 32'(n), 32'd3);
        chk("unlock_data", 32'(douta), 32'h5A);

        // cen gating
        cena = 1'b0;
        rnwa[1] = 1'b1; addra[13 +: 13] = 13'h0010; reqa[1] = 1'b1;
        acka_cnt = 0;
        repeat (10) step();
        chk("cen_noack", 32'(acka_cnt), 32'd0);
        cena = 1'b1;
        do_acc(0, 1, 1'b1, 'h0010, 8'h00, n);
        chk("cen_latency", 32'(n), 32'd2);
        chk("cen_data", 32'(douta), 32'h33);

        // Asynchronous reset during the ACCESS of a write
        step();
        rnwa[0] = 1'b0; addra[0 +: 13] = 13'h0010; dina[0 +: 8] = 8'hFF; reqa[0] = 1'b1;
        step();
        chk("mw_busy_pre", 32'(busya), 32'd1);
        #1 rstn = 1'b0;
        model_reset(0); model_reset(1);
        reqa = 2'b00;
        #1;
        chk("mw_busy_now", 32'(busya), 32'd0);
        chk("mw_ack_now", 32'(acka), 32'd0);
        check_all();
        step();
        rstn = 1'b1;
        do_acc(0, 0, 1'b1, 'h0010, 8'h00, n);
        chk("mw_discard", 32'(douta), 32'h33);

        // PORTS=4: preload, then all ports read together
        for (int p = 0; p < 4; p++) do_acc(1, p, 1'b0, kb[p], 8'hA0 + 8'(p), n);
        step();
        for (int p = 0; p < 4; p++) addrb[p*10 +: 10] = 10'(kb[p]);
        rnwb = 4'hF; reqb = 4'hF;
        qb.delete(); qdb.delete();
        for (int i = 0; i < 30 && qb.size() < 5; i++) step();
        reqb = 4'h0;
        chk("p4_count", 32'(qb.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("p4_order", (i < qb.size()) ? 32'(qb[i]) : 32'hFFFF, 32'd1 << (i % 4));
            chk("p4_data", (i < qdb.size()) ? 32'(qdb[i]) : 32'hFFFF, 32'hA0 + 32'(i % 4));
        end

        // Randomized traffic on both instances
        for (int t = 0; t < 600; t++) begin
            cena  = ($urandom_range(0, 3) != 0);
            cenb  = ($urandom_range(0, 3) != 0);
            reqa  = 2'($urandom); rnwa = 2'($urandom); locka = 2'($urandom_range(0, 3) == 0 ? 1 : 0);
            reqb  = 4'($urandom); rnwb = 4'($urandom); lockb = 4'($urandom) & 4'($urandom);
            for (int p = 0; p < 2; p++) addra[p*13 +: 13] = 13'(ka[$urandom_range(0, 3)]);
            for (int p = 0; p < 4; p++) addrb[p*10 +: 10] = 10'(kb[$urandom_range(0, 3)]);
            dina = 16'($urandom); dinb = $urandom;
            step();
        end
        reqa = '0; reqb = '0; locka = '0; lockb = '0; cena = 1'b1; cenb = 1'b1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
